// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the read-side FSM state type.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } rd_state_e;

endpackage

// File: rtl/axi_lite_ar_skid.sv
// One-entry read-address buffer: holds a decoded word index and its error flag
// so a new AR can be accepted while the previous read is still in flight.
module axi_lite_ar_skid #(
    parameter int unsigned IdxW = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [IdxW-1:0] idx_i,
    input  logic            err_i,
    output logic            valid_o,
    output logic [IdxW-1:0] idx_o,
    output logic            err_o
);

    logic            valid_d, valid_q;
    logic [IdxW-1:0] idx_d, idx_q;
    logic            err_d, err_q;

    // Load wins over clear; the owner never requests both in one cycle.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        err_d   = err_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            idx_d   = idx_i;
            err_d   = err_i;
        end
    end

    // Buffer storage, synchronous active-low reset empties it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign valid_o = valid_q;
    assign idx_o   = idx_q;
    assign err_o   = err_q;

endmodule

// File: rtl/axi_lite_read_slave.sv
// AXI4-Lite read responder in front of a fixed-latency register bank.
// Optional AXI_LITE_RD_SKID_EN adds a one-entry AR buffer so a second read
// can be accepted while the first is in flight.
module axi_lite_read_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    input  logic [ADDR_WIDTH-1:0]       ARADDR,
    input  logic [2:0]                  ARPROT,
    output logic                        RVALID,
    input  logic                        RREADY,
    output logic [DATA_WIDTH-1:0]       RDATA,
    output logic [1:0]                  RRESP,
    output logic                        reg_rd_en,
    output logic [$clog2(NUM_REGS)-1:0] reg_rd_addr,
    input  logic [DATA_WIDTH-1:0]       reg_rd_data
);

    localparam int unsigned     IdxW     = $clog2(NUM_REGS);
    localparam int unsigned     WordW    = ADDR_WIDTH - 2;
    localparam logic [WordW-1:0] NumRegsW = WordW'(NUM_REGS);

    rd_state_e             state_d, state_q;
    logic                  err_d, err_q;
    logic                  arready_d, arready_q;
    logic                  rvalid_d, rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
    logic [1:0]            rresp_d, rresp_q;
    logic                  rd_en_d, rd_en_q;
    logic [IdxW-1:0]       rd_addr_d, rd_addr_q;

    logic                  ar_hs, r_hs;
    logic [ADDR_WIDTH-1:0] byte_off;
    logic [WordW-1:0]      word_off;
    logic                  dec_err;
    logic [IdxW-1:0]       dec_idx;
    logic                  unused_bits;

    assign ar_hs = ARVALID && arready_q;
    assign r_hs  = rvalid_q && RREADY;

    // Decode the incoming byte address into a word index; byte lane bits are dropped.
    always_comb begin
        byte_off = ARADDR - BASE_ADDR;
        word_off = byte_off[ADDR_WIDTH-1:2];
        dec_err  = (ARADDR < BASE_ADDR) || (word_off >= NumRegsW);
        dec_idx  = dec_err ? '0 : word_off[IdxW-1:0];
    end

    assign unused_bits = ^{ARPROT, byte_off[1:0]};

`ifdef AXI_LITE_RD_SKID_EN
    logic            skid_load, skid_clear, skid_valid, skid_err;
    logic [IdxW-1:0] skid_idx;

    axi_lite_ar_skid #(
        .IdxW (IdxW)
    ) u_ar_skid (
        .clk_i   (ACLK),
        .rst_ni  (ARESETn),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .idx_i   (dec_idx),
        .err_i   (dec_err),
        .valid_o (skid_valid),
        .idx_o   (skid_idx),
        .err_o   (skid_err)
    );
`endif

    // Next-state and registered-output logic of the read FSM.
    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
`ifdef AXI_LITE_RD_SKID_EN
        skid_load  = 1'b0;
        skid_clear = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (ar_hs) begin
                    state_d   = StReq;
                    rd_en_d   = !dec_err;
                    rd_addr_d = dec_idx;
                    err_d     = dec_err;
                end
            end
            StReq: begin
                state_d = StWait;
            end
            StWait: begin
                // Bank data is valid now, one cycle after the strobe was sampled.
                state_d  = StResp;
                rvalid_d = 1'b1;
                rdata_d  = err_q ? '0 : reg_rd_data;
                rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
            end
            StResp: begin
                if (r_hs) begin
                    rvalid_d = 1'b0;
                    state_d  = StIdle;
`ifdef AXI_LITE_RD_SKID_EN
                    // Chain straight into the next read: buffered AR first, else a
                    // handshake landing on this very edge.
                    if (skid_valid) begin
                        state_d    = StReq;
                        rd_en_d    = !skid_err;
                        rd_addr_d  = skid_idx;
                        err_d      = skid_err;
                        skid_clear = 1'b1;
                    end else if (ar_hs) begin
                        state_d   = StReq;
                        rd_en_d   = !dec_err;
                        rd_addr_d = dec_idx;
                        err_d     = dec_err;
                    end
`endif
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
`ifdef AXI_LITE_RD_SKID_EN
        skid_load = ar_hs && (state_q != StIdle) && !((state_q == StResp) && r_hs);
        arready_d = !((skid_valid && !skid_clear) || skid_load);
`else
        arready_d = (state_d == StIdle);
`endif
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= StIdle;
            err_q     <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign ARREADY     = arready_q;
    assign RVALID      = rvalid_q;
    assign RDATA       = rdata_q;
    assign RRESP       = rresp_q;
    assign reg_rd_en   = rd_en_q;
    assign reg_rd_addr = rd_addr_q;

endmodule

// File: doc/axi_lite_read_slave.md
Name: axi_lite_read_slave

Overview:
- AXI4-Lite read-side responder: accepts the read address (AR) channel and returns the read data (R) channel.
- Accepted addresses are decoded against a local register window and issued to a register bank over a fixed-latency read port.
- The response carries the returned data with RRESP = OKAY, or zero data with SLVERR when the address is out of range.
- Sits on the slave end of the AXI4-Lite interconnect, as the read counterpart of the write-address path.

Parameters:
- ADDR_WIDTH, 32, width of ARADDR
- DATA_WIDTH, 32, width of RDATA and reg_rd_data
- NUM_REGS, 16, number of 32-bit words in the register window (>=2)
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset
- ARVALID  in  1  master read-address valid
- ARREADY  out  1  slave ready for read address
- ARADDR  in  ADDR_WIDTH  byte read address
- ARPROT  in  3  protection attributes; accepted and ignored
- RVALID  out  1  read data valid
- RREADY  in  1  master ready for read data
- RDATA  out  DATA_WIDTH  read data
- RRESP  out  2  read response
- reg_rd_en  out  1  one-cycle read strobe to the register bank
- reg_rd_addr  out  $clog2(NUM_REGS)  word index
- reg_rd_data  in  DATA_WIDTH  bank data, valid the cycle after reg_rd_en is sampled

Interface decisions:
- ARESETn: synchronous, active-low.
- ACLK: clock.

Behaviour:
- All outputs are registered.
- Reset (ARESETn=0 at an ACLK edge): state IDLE, ARREADY=0, RVALID=0, RDATA=0, RRESP=2'b00, reg_rd_en=0, reg_rd_addr=0.
- The first edge with ARESETn=1 sets ARREADY=1.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - ARREADY=1.
  - On ARVALID&ARREADY at edge E0, capture ARADDR.
  - Decode: off = ARADDR - BASE_ADDR; idx = off[..:2]; ARADDR[1:0] ignored.
  - err = (ARADDR < BASE_ADDR) | (idx >= NUM_REGS).
  - Go to REQ; ARREADY=0.
  - reg_rd_en = !err for exactly one cycle; reg_rd_addr = idx (0 on err).
- REQ -> WAIT at E1; reg_rd_en returns to 0.
- WAIT -> RESP at E2:
  - Capture RDATA = err ? 0 : reg_rd_data.
  - RRESP = err ? 2'b10 (SLVERR) : 2'b00 (OKAY).
  - RVALID=1.
- Fixed latency: RVALID rises two edges after the AR handshake, for both OKAY and SLVERR.
- RESP:
  - RVALID, RDATA and RRESP are held stable until RVALID&RREADY.
  - On that edge: RVALID=0, ARREADY=1, state IDLE.
- RREADY held high early is legal; the handshake completes on the first edge of RESP.
- RREADY low indefinitely: stall in RESP with no timeout.
- One outstanding transaction only (without the optional feature); ARVALID outside IDLE is ignored.
- Reset mid-transaction: the transaction is abandoned; RVALID and reg_rd_en drop at that edge; no response is issued.
- ARVALID withdrawn before ARREADY: no capture, no side effect.

Optional Feature:
- Macro: AXI_LITE_RD_SKID_EN.
- Enabled:
  - A one-entry AR buffer is added.
  - ARREADY is also 1 in REQ, WAIT and RESP while the buffer is empty.
  - A handshake in those states stores the address and error flag.
  - On RVALID&RREADY with the buffer full, go directly to REQ with the buffered address and clear the buffer.
  - Back-to-back reads: the next RVALID occurs 2 edges after the previous R handshake.
  - Reset clears the buffer.
- Disabled: ARREADY is 1 only in IDLE; the behaviour is as described above.

Decomposition:
- Package axi_lite_pkg:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Read FSM state enum {IDLE, REQ, WAIT, RESP}.
- Sub-module axi_lite_ar_skid: one-entry address/err buffer with valid flag; instantiated only under AXI_LITE_RD_SKID_EN.
- Address decode remains inline.

Test Plan:
- Reset then single read, ARADDR=0x08, bank returns 0xDEADBEEF -> reg_rd_en pulses once with reg_rd_addr=2; RVALID rises 2 edges after the AR handshake; RDATA=0xDEADBEEF, RRESP=00.
- Out-of-range read, ARADDR=0x40 with NUM_REGS=16 -> reg_rd_en never asserts; RDATA=0, RRESP=10, same latency.
- RREADY held low 5 cycles -> RVALID, RDATA and RRESP stable across all 5 cycles; ARREADY=0 throughout (macro off); completes when RREADY=1.
- ARESETn=0 asserted in WAIT -> at that edge RVALID=0, reg_rd_en=0, ARREADY=0; first edge after release gives ARREADY=1; no stale response.
- Misaligned ARADDR=0x0B -> reg_rd_addr=2, RRESP=00.
- Macro on, second AR (0x04) presented during RESP with RREADY=0 -> accepted into the buffer; after the R handshake reg_rd_addr=1 on the next cycle; second RVALID 2 edges later.
